if_id_pipe: RTL
===============

IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 Parameter LANES, default 2, number of instruction lanes carried per fetch packet (lane 0 vector instruction, lane 1 scalar operand).
REQ-002 Parameter IW, default 32, instruction width per lane in bits.
REQ-003 Parameter AW, default 32, instruction address width in bits.
REQ-004 Parameter NOP, default 32'h00000001, IW-bit bubble encoding driven on every lane when no packet is valid.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 flush_i  input  1  synchronous pipeline flush (branch/trap redirect).
REQ-008 hold_i  input  1  stall from ctrl; freezes both enqueue and dequeue.
REQ-009 in_valid_i  input  1  fetch packet present on inst_i/inst_addr_i.
REQ-010 in_ready_o  output  1  block can accept a packet this cycle.
REQ-011 inst_i  input  LANES*IW  packed lanes; lane k occupies bits [k*IW +: IW].
REQ-012 inst_addr_i  input  AW  packet address.
REQ-013 out_valid_o  output  1  packet presented to decode.
REQ-014 out_ready_i  input  1  decode accepts the presented packet.
REQ-015 inst_o  output  LANES*IW  packed lanes to decode, same lane packing as inst_i.
REQ-016 inst_addr_o  output  AW  address of the presented packet.
REQ-017 count_o  output  2  entries held (0, 1 or 2).

Function
REQ-018 Storage: two-entry skid buffer, MAIN (drives outputs) and SKID, each holding LANES*IW instruction bits plus AW address bits; states EMPTY (count 0), ONE (count 1), TWO (count 2).
REQ-019 in_ready_o = (count != 2) && !hold_i && !flush_i.
REQ-020 out_valid_o = (count != 0) && !hold_i && !flush_i.
REQ-021 accept = in_valid_i && in_ready_o; fire = out_valid_o && out_ready_i.
REQ-022 When count == 0, inst_o drives NOP on every lane and inst_addr_o drives 0; otherwise both drive MAIN contents, including while hold_i is high.
REQ-023 EMPTY: accept -> ONE, MAIN <= input.
REQ-024 ONE: accept && fire -> ONE, MAIN <= input; accept only -> TWO, SKID <= input; fire only -> EMPTY; neither -> ONE, MAIN unchanged.
REQ-025 TWO: fire -> ONE, MAIN <= SKID; otherwise TWO, both entries unchanged; no accept is possible in TWO.
REQ-026 Packets leave in acceptance order; no packet is duplicated or dropped except by flush.
REQ-027 Latency: a packet accepted in cycle N is presented on the outputs in cycle N+1 when the buffer was empty, or when it was ONE with fire in cycle N.
REQ-028 Throughput: with in_valid_i and out_ready_i held high and hold_i low, one packet transfers per cycle with count steady at 1.
REQ-029 flush_i has priority over all other inputs: at the next edge count <= 0, and MAIN/SKID contents are don't-care; the packet on the input is discarded in the flush cycle.
REQ-030 hold_i blocks enqueue and dequeue; state and outputs stay frozen; flush_i && hold_i together flushes.
REQ-031 count_o equals the current state encoding (EMPTY = 0, ONE = 1, TWO = 2); value 3 is unreachable.
REQ-032 Outputs are driven purely from registers, count, hold_i and flush_i; out_ready_i has no combinational path to in_ready_o.

Reset
REQ-033 On rstn low, asynchronously: count_o = 0, out_valid_o = 0, inst_o = NOP on every lane, inst_addr_o = 0, SKID cleared to 0.
REQ-034 Reset asserted mid-operation discards both entries; in_ready_o = 1 in the first cycle after release provided hold_i = 0 and flush_i = 0.

Verification
REQ-035 Reset, then idle -> out_valid_o = 0, inst_o = {32'h00000001, 32'h00000001}, inst_addr_o = 0, in_ready_o = 1.
REQ-036 Stream 8 packets at addr 0x100, 0x104, ... with out_ready_i = 1 -> each appears 1 cycle later in order, count_o = 1 throughout, one packet per cycle.
REQ-037 Push 0x200 and 0x204 with out_ready_i = 0 -> count_o = 2, in_ready_o = 0; release out_ready_i -> 0x200 then 0x204 delivered; a third pushed packet 0x208 is not lost.
REQ-038 Buffer at count 2, assert flush_i together with in_valid_i (addr 0x300) -> next cycle count_o = 0, inst_o = NOP, and 0x300 is never delivered.
REQ-039 hold_i high for 3 cycles with count 1 and in_valid_i = out_ready_i = 1 -> in_ready_o = out_valid_o = 0, inst_addr_o frozen, count_o = 1; transfers resume the cycle hold_i drops.
REQ-040 Assert rstn low while count_o = 2 -> outputs return to the REQ-033 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_id_pipe.sv
// if_id_pipe: two-entry skid buffer between instruction fetch and decode.
// Ports: clk/rstn (async active-low reset), flush_i (sync flush), hold_i (stall),
//        in_valid_i/in_ready_o/inst_i/inst_addr_i (fetch side),
//        out_valid_o/out_ready_i/inst_o/inst_addr_o (decode side), count_o (entries held).
module if_id_pipe #(
    parameter int              LANES = 2,
    parameter int              IW    = 32,
    parameter int              AW    = 32,
    parameter logic [IW-1:0]   NOP   = IW'(32'h00000001)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush_i,
    input  logic                hold_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [LANES*IW-1:0] inst_i,
    input  logic [AW-1:0]       inst_addr_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [LANES*IW-1:0] inst_o,
    output logic [AW-1:0]       inst_addr_o,
    output logic [1:0]          count_o
);
    localparam int DW = LANES * IW;

    logic [1:0]    count_q, count_d;
    logic [DW-1:0] main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
    logic [AW-1:0] main_addr_q, main_addr_d, skid_addr_q, skid_addr_d;
    logic          accept, fire;

    // Handshakes depend only on state, hold and flush, never on the opposite side's ready.
    assign in_ready_o  = (count_q != 2'd2) && !hold_i && !flush_i;
    assign out_valid_o = (count_q != 2'd0) && !hold_i && !flush_i;
    assign accept      = in_valid_i && in_ready_o;
    assign fire        = out_valid_o && out_ready_i;

    assign inst_o      = (count_q == 2'd0) ? {LANES{NOP}} : main_inst_q;
    assign inst_addr_o = (count_q == 2'd0) ? '0 : main_addr_q;
    assign count_o     = count_q;

    always_comb begin
        count_d     = count_q;
        main_inst_d = main_inst_q;
        main_addr_d = main_addr_q;
        skid_inst_d = skid_inst_q;
        skid_addr_d = skid_addr_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (accept) begin
                        count_d     = 2'd1;
                        main_inst_d = inst_i;
                        main_addr_d = inst_addr_i;
                    end
                end
                2'd1: begin
                    if (accept && fire) begin
                        main_inst_d = inst_i;
                        main_addr_d = inst_addr_i;
                    end else if (accept) begin
                        count_d     = 2'd2;
                        skid_inst_d = inst_i;
                        skid_addr_d = inst_addr_i;
                    end else if (fire) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (fire) begin
                        count_d     = 2'd1;
                        main_inst_d = skid_inst_q;
                        main_addr_d = skid_addr_q;
                    end
                end
                default: count_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q     <= 2'd0;
            main_inst_q <= '0;
            main_addr_q <= '0;
            skid_inst_q <= '0;
            skid_addr_q <= '0;
        end else begin
            count_q     <= count_d;
            main_inst_q <= main_inst_d;
            main_addr_q <= main_addr_d;
            skid_inst_q <= skid_inst_d;
            skid_addr_q <= skid_addr_d;
        end
    end
endmodule
